// File: rtl/d_branch_resolve_pkg.sv
// Shared constants for decode-stage branch resolution: condition-select
// codes, branch-history counter reset value and the saturating update helper.
// Pure constants/functions: no latency, no flow control.
package d_branch_resolve_pkg;

  // cmp_op condition-select codes; 3'd7 is reserved and behaves as CMP_NONE
  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_BEQ  = 3'd1;
  localparam logic [2:0] CMP_BNE  = 3'd2;
  localparam logic [2:0] CMP_BLEZ = 3'd3;
  localparam logic [2:0] CMP_BGEZ = 3'd4;
  localparam logic [2:0] CMP_BGTZ = 3'd5;
  localparam logic [2:0] CMP_BLTZ = 3'd6;

  // Every history counter starts weakly not-taken
  localparam logic [1:0] BHT_RST = 2'b01;

  // 2-bit saturating counter step: up on taken, down on not-taken
  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/d_bht.sv
// Branch history table: array of 2-bit saturating counters, async read of the
// counter MSB, one synchronous saturating update per clock. Read has zero
// latency and no bypass (a write is seen from the next cycle); never stalls.
// Ports: clk, reset (async, active-high -> all counters BHT_RST),
//        rd_idx/rd_taken (lookup), upd_en/upd_idx/upd_taken (training).
module d_bht
  import d_branch_resolve_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr [BHT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr[i] <= BHT_RST;
    end else if (upd_en) begin
      ctr[upd_idx] <= bht_next(ctr[upd_idx], upd_taken);
    end
  end

  // Prediction is the counter MSB (2,3 = taken)
  assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/d_branch_resolve.sv
// Decode-stage branch resolution: evaluates the branch condition on forwarded
// rs/rt, flags mispredictions, counts them (saturating) and, when the
// BHT_PREDICT_EN macro is defined, trains a PC-indexed 2-bit counter table
// feeding a fetch prediction (otherwise prediction is static not-taken).
// Latency: jump/mispredict/f_pred_taken combinational; state updates on clk.
// Backpressure: d_stall freezes all state; outputs stay combinationally valid.
// Ports: clk, reset (async, active-high); f_pc -> f_pred_taken (fetch lookup);
//        d_valid, d_stall, d_pc, d_pred_taken, rs, rt, cmp_op (decode inputs);
//        jump, mispredict, miss_count (resolution results).
module d_branch_resolve
  import d_branch_resolve_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             d_valid,
  input  logic             d_stall,
  input  logic [PC_W-1:0]  d_pc,
  input  logic             d_pred_taken,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       cmp_op,
  output logic             jump,
  output logic             mispredict,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic eqz, ltz, gtz;
  logic cond;
  logic br_op;
  logic is_br;
  logic upd_en;

  // Condition evaluation; compares against zero look at rs only
  always_comb begin
    eqz   = (rs == '0);
    ltz   = rs[WIDTH-1];
    gtz   = !eqz && !ltz;
    cond  = 1'b0;
    br_op = 1'b1;
    case (cmp_op)
      CMP_BEQ:  cond = (rs == rt);
      CMP_BNE:  cond = (rs != rt);
      CMP_BLEZ: cond = ltz || eqz;
      CMP_BGEZ: cond = !ltz;
      CMP_BGTZ: cond = gtz;
      CMP_BLTZ: cond = ltz;
      default:  br_op = 1'b0;  // CMP_NONE and the reserved code
    endcase
  end

  assign is_br      = d_valid && br_op;
  assign jump       = d_valid && cond;
  assign mispredict = is_br && (jump != d_pred_taken);
  assign upd_en     = is_br && !d_stall;

  // Mispredict counter holds at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_count <= '0;
    end else if (mispredict && !d_stall && (miss_count != '1)) begin
      miss_count <= miss_count + CNT_W'(1);
    end
  end

`ifdef BHT_PREDICT_EN
  // Word-aligned PCs: drop the two byte-offset bits; aliasing PCs share a counter
  d_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (f_pc[IDX_W+1:2]),
    .rd_taken  (f_pred_taken),
    .upd_en    (upd_en),
    .upd_idx   (d_pc[IDX_W+1:2]),
    .upd_taken (jump)
  );
`else
  // Static not-taken: no table, PCs and the update strobe are not needed
  assign f_pred_taken = 1'b0;
  logic unused_no_bht;
  assign unused_no_bht = ^{upd_en, IDX_W[0]};
`endif

  // Only the index bits of the PCs feed the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc, d_pc};

endmodule
